// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: arbitrates a SECDED memory array between a host port and a background scrubber,
// with saturating SEC/DED counters. Define ECC_SCRUB_DED_LOG_EN to add first-DED address capture.
module ecc_scrub_ctrl #(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned SCRUB_INTERVAL = 256,
    parameter int unsigned STARVE_LIMIT   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scrub_en,
    input  logic              cnt_clr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_sec,
    input  logic              mem_ded,
    output logic [7:0]        sec_count,
    output logic [7:0]        ded_count,
    output logic              ded_irq,
    output logic              scrub_wrap
`ifdef ECC_SCRUB_DED_LOG_EN
    ,
    output logic              ded_log_valid,
    output logic [ADDR_W-1:0] ded_log_addr
`endif
);

    localparam int unsigned TMR_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned CNT_W = 8;

    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);
    localparam logic [STV_W-1:0]  STV_MAX  = STV_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SCRUB_CHK = 2'd1,
        S_SCRUB_WB  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic              r_scrub_pending;
    logic [STV_W-1:0]  r_starve;
    logic [ADDR_W-1:0] r_scrub_ptr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_host_rd;
    logic [CNT_W-1:0]  r_sec_count;
    logic [CNT_W-1:0]  r_ded_count;
    logic              r_ded_irq;
    logic              r_scrub_wrap;

    logic w_scrub_go;
    logic w_host_gnt;
    logic w_ptr_adv;
    logic w_resp;
    logic w_sec_evt;
    logic w_ded_evt;

    // Arbitration and array drive; reset suppresses every access, abandoning a pending write-back
    always_comb begin
        w_state_nxt = r_state;
        w_scrub_go  = 1'b0;
        w_host_gnt  = 1'b0;
        w_ptr_adv   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = host_addr;
        mem_wdata   = host_wdata;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (r_scrub_pending && (!host_req || (r_starve == STV_MAX))) begin
                        w_scrub_go  = 1'b1;
                        mem_req     = 1'b1;
                        mem_addr    = r_scrub_ptr;
                        w_state_nxt = S_SCRUB_CHK;
                    end else if (host_req) begin
                        w_host_gnt = 1'b1;
                        mem_req    = 1'b1;
                        mem_we     = host_we;
                    end
                end
                S_SCRUB_CHK: begin
                    if (mem_sec) begin
                        w_state_nxt = S_SCRUB_WB;
                    end else begin
                        w_ptr_adv   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_SCRUB_WB: begin
                    mem_req     = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = r_scrub_ptr;
                    mem_wdata   = r_wb_data;
                    w_ptr_adv   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign host_gnt  = w_host_gnt;
    assign w_resp    = r_host_rd || (r_state == S_SCRUB_CHK);
    assign w_sec_evt = w_resp && mem_sec;
    assign w_ded_evt = w_resp && mem_ded;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scrub timer, pending flag and host-starvation counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer         <= '0;
            r_scrub_pending <= 1'b0;
            r_starve        <= '0;
        end else begin
            if (w_scrub_go) begin
                r_starve <= '0;
            end else if (w_host_gnt && r_scrub_pending && (r_starve != STV_MAX)) begin
                r_starve <= r_starve + STV_W'(1);
            end
            if (scrub_en) begin
                if (r_timer == TMR_LAST) begin
                    r_timer         <= '0;
                    r_scrub_pending <= 1'b1;
                end else begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (w_scrub_go) begin
                        r_scrub_pending <= 1'b0;
                    end
                end
            end else begin
                r_timer         <= '0;
                r_scrub_pending <= 1'b0;
            end
        end
    end

    // Scrub pointer, write-back word and host read tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scrub_ptr  <= '0;
            r_wb_data    <= '0;
            r_scrub_wrap <= 1'b0;
            r_host_rd    <= 1'b0;
        end else begin
            if ((r_state == S_SCRUB_CHK) && mem_sec) begin
                r_wb_data <= mem_rdata;
            end
            if (w_ptr_adv) begin
                r_scrub_ptr <= r_scrub_ptr + ADDR_W'(1);
            end
            r_scrub_wrap <= w_ptr_adv && (r_scrub_ptr == PTR_LAST);
            r_host_rd    <= w_host_gnt && !host_we;
        end
    end

    // Saturating error counters; clear has priority over a same-cycle event
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sec_count <= '0;
            r_ded_count <= '0;
            r_ded_irq   <= 1'b0;
        end else begin
            if (cnt_clr) begin
                r_sec_count <= '0;
                r_ded_count <= '0;
            end else begin
                if (w_sec_evt && (r_sec_count != CNT_MAX)) begin
                    r_sec_count <= r_sec_count + CNT_W'(1);
                end
                if (w_ded_evt && (r_ded_count != CNT_MAX)) begin
                    r_ded_count <= r_ded_count + CNT_W'(1);
                end
            end
            r_ded_irq <= w_ded_evt;
        end
    end

    assign host_rvalid = r_host_rd;
    assign host_rdata  = r_host_rd ? mem_rdata : '0;
    assign host_err    = r_host_rd && mem_ded;
    assign sec_count   = r_sec_count;
    assign ded_count   = r_ded_count;
    assign ded_irq     = r_ded_irq;
    assign scrub_wrap  = r_scrub_wrap;

`ifdef ECC_SCRUB_DED_LOG_EN
    logic [ADDR_W-1:0] r_host_addr;
    logic              r_log_valid;
    logic [ADDR_W-1:0] r_log_addr;

    // First DED address since reset or clear; host responses use the address granted a cycle earlier
    always_ff @(posedge clock) begin
        if (reset) begin
            r_host_addr <= '0;
            r_log_valid <= 1'b0;
            r_log_addr  <= '0;
        end else begin
            if (w_host_gnt) begin
                r_host_addr <= host_addr;
            end
            if (cnt_clr) begin
                r_log_valid <= 1'b0;
                r_log_addr  <= '0;
            end else if (w_ded_evt && !r_log_valid) begin
                r_log_valid <= 1'b1;
                r_log_addr  <= r_host_rd ? r_host_addr : r_scrub_ptr;
            end
        end
    end

    assign ded_log_valid = r_log_valid;
    assign ded_log_addr  = r_log_addr;
`endif

endmodule
